delay_monitor: RTL
==================

// Module: delay_monitor
// PURPOSE
//  Receive-side checker for the periodic single-cycle "sig" pulse from the DELAY
//  pulse generator. Measures the gap between successive pulses and compares it to
//  the expected period P = N+1 cycles. Declares lock after LOCK_CNT good gaps in a
//  row, and flags early or missing pulses. Sits in the same clock domain as the generator.
// PARAMETERS
//  N         100000  generator terminal count; expected period P = N+1 cycles
//  CBITS     17      gap counter width; P+TOL must be < 2**CBITS (elaboration check)
//  TOL       0       accepted gap window is [P-TOL, P+TOL]; requires TOL < P
//  LOCK_CNT  4       consecutive good gaps needed to assert locked (>=1)
//  LBITS     3       streak counter width; LOCK_CNT < 2**LBITS
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  sig        in   1      pulse from generator, sampled on clk
//  locked     out  1      level: period verified
//  err_early  out  1      1-cycle pulse: gap < P-TOL
//  err_late   out  1      1-cycle pulse: no pulse by gap P+TOL (timeout)
//  gap        out  CBITS  last measured gap, held until the next pulse
//  gap_vld    out  1      1-cycle pulse: gap updated
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=SEARCH, cnt=0, streak=0, all outputs 0.
//  - All outputs are registered: the effect of sig sampled at edge k is visible after edge k.
//  - cnt: loaded with 1 on every sampled sig=1; otherwise cnt+1, saturating at 2**CBITS-1.
//    At a pulse, the gap equals the cnt value before the load (edge-to-edge distance).
//  - States:
//    SEARCH: ignore cnt. On sig=1 go to MEASURE, streak=0. No gap_vld and no errors.
//    MEASURE and LOCKED, on sig=1:
//      gap<=cnt, gap_vld=1;
//      if cnt in window: streak++ (saturate at LOCK_CNT);
//        go to LOCKED when the new streak==LOCK_CNT;
//      else (cnt<P-TOL): err_early=1, streak=0, locked=0, state MEASURE.
//    MEASURE and LOCKED, on sig=0 with cnt==P+TOL:
//      err_late=1, streak=0, locked=0, state SEARCH.
//  - locked=1 exactly while state==LOCKED.
//  - Boundaries:
//    * A pulse in the same cycle as cnt==P+TOL is a good gap; no timeout.
//    * Back-to-back sig=1 gives gap=1, which is early unless P-TOL<=1.
//    * Gap exactly P-TOL is good.
//    * err_early, err_late and gap_vld never assert together, except that
//      err_early coincides with gap_vld.
//    * rst_n low mid-measurement: immediate return to reset state. The first pulse
//      after reset only starts a measurement.
//    * sig held high continuously: every cycle is an early gap.
// CONFIGURATION
//  DELAY_MONITOR_STATS_EN defined: adds output miss_cnt [15:0].
//    - Increments on each err_early or err_late and saturates at 16'hFFFF.
//    - Cleared only by reset.
//  DELAY_MONITOR_STATS_EN undefined: no miss_cnt port and no counter logic.
//  All other behaviour is identical in both builds.
// TESTING  (N=8 so P=9, TOL=1, LOCK_CNT=3, CBITS=5)
//  1. Reset, then pulses every 9 cycles, x5.
//     -> gap_vld on pulses 2-5 with gap=9; locked rises with pulse 4, no errors.
//  2. Locked, then the next pulse comes after 7 cycles.
//     -> err_early=1, gap=7, locked=0; three more good gaps relock.
//  3. Locked, then the pulse is removed.
//     -> err_late exactly 10 cycles after the last pulse; state SEARCH, locked=0, gap unchanged.
//  4. Gaps of 8, 10, 9 after the first pulse.
//     -> all good, locked after the third gap; a gap of 10 with sig at the timeout edge gives no err_late.
//  5. rst_n asserted low mid-gap while locked.
//     -> outputs 0 immediately without waiting for clk; the next pulse gives no gap_vld.
//  6. STATS_EN build: 2 early gaps plus 1 timeout -> miss_cnt=3; non-STATS build: port absent.

Source files
------------

// File: rtl/delay_monitor.sv
// ---------------------------------------------------------------------------
// delay_monitor
//   Receive-side checker for the periodic single-cycle pulse of the DELAY
//   pulse generator (same clock domain). It measures the edge-to-edge gap
//   between successive pulses and compares it with the expected period
//   P = N+1 cycles. A gap is accepted when it lies in [P-TOL, P+TOL].
//   The block declares lock after LOCK_CNT good gaps in a row, and it flags
//   early pulses (gap < P-TOL) and missing pulses (no pulse by gap P+TOL).
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   sig        in   1      generator pulse, sampled on clk
//   locked     out  1      level, high while the period is verified
//   err_early  out  1      1-cycle pulse: gap < P-TOL
//   err_late   out  1      1-cycle pulse: timeout at gap P+TOL
//   gap        out  CBITS  last measured gap, held until the next pulse
//   gap_vld    out  1      1-cycle pulse: gap updated
//   miss_cnt   out  16     saturating count of early plus late errors
//                          (only present when DELAY_MONITOR_STATS_EN is defined)
//
// Build option
//   DELAY_MONITOR_STATS_EN : adds the miss_cnt output and its counter.
// ---------------------------------------------------------------------------
module delay_monitor #(
    parameter int unsigned N        = 100000,
    parameter int unsigned CBITS    = 17,
    parameter int unsigned TOL      = 0,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LBITS    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig,
    output logic             locked,
    output logic             err_early,
    output logic             err_late,
    output logic [CBITS-1:0] gap,
    output logic             gap_vld
`ifdef DELAY_MONITOR_STATS_EN
    ,
    output logic [15:0]      miss_cnt
`endif
);

    // Parameter sanity checks, evaluated at elaboration.
    if (N + 1 + TOL >= (64'd1 << CBITS)) begin : g_chk_cbits
        $error("delay_monitor: P+TOL does not fit in CBITS");
    end
    if (TOL >= N + 1) begin : g_chk_tol
        $error("delay_monitor: TOL must be smaller than P");
    end
    if (LOCK_CNT < 1 || LOCK_CNT >= (64'd1 << LBITS)) begin : g_chk_lock
        $error("delay_monitor: LOCK_CNT must be >= 1 and fit in LBITS");
    end

    localparam logic [1:0] ST_SEARCH  = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    localparam logic [CBITS-1:0] WIN_LO     = CBITS'(N + 1 - TOL);
    localparam logic [CBITS-1:0] WIN_HI     = CBITS'(N + 1 + TOL);
    localparam logic [CBITS-1:0] CNT_MAX    = '1;
    localparam logic [LBITS-1:0] STREAK_MAX = LBITS'(LOCK_CNT);

    logic [1:0]       state_q,   state_d;
    logic [CBITS-1:0] cnt_q,     cnt_d;
    logic [LBITS-1:0] streak_q,  streak_d;
    logic [CBITS-1:0] gap_q,     gap_d;
    logic             gap_vld_q, gap_vld_d;
    logic             early_q,   early_d;
    logic             late_q,    late_d;
    logic             locked_q,  locked_d;

    logic             in_win;
    logic [LBITS-1:0] streak_inc;

    assign in_win     = (cnt_q >= WIN_LO) && (cnt_q <= WIN_HI);
    assign streak_inc = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        streak_d  = streak_q;
        gap_d     = gap_q;
        gap_vld_d = 1'b0;
        early_d   = 1'b0;
        late_d    = 1'b0;

        // Gap counter runs in every state; a pulse restarts it at 1 so the
        // value seen at the next pulse is the edge-to-edge distance.
        if (sig) begin
            cnt_d = CBITS'(1);
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            ST_SEARCH: begin
                if (sig) begin
                    state_d  = ST_MEASURE;
                    streak_d = '0;
                end
            end
            ST_MEASURE, ST_LOCKED: begin
                if (sig) begin
                    gap_d     = cnt_q;
                    gap_vld_d = 1'b1;
                    if (in_win) begin
                        streak_d = streak_inc;
                        if (streak_inc == STREAK_MAX) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        early_d  = 1'b1;
                        streak_d = '0;
                        state_d  = ST_MEASURE;
                    end
                end else if (cnt_q == WIN_HI) begin
                    late_d   = 1'b1;
                    streak_d = '0;
                    state_d  = ST_SEARCH;
                end
            end
            default: begin
                state_d  = ST_SEARCH;
                streak_d = '0;
            end
        endcase

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_SEARCH;
            cnt_q     <= '0;
            streak_q  <= '0;
            gap_q     <= '0;
            gap_vld_q <= 1'b0;
            early_q   <= 1'b0;
            late_q    <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            streak_q  <= streak_d;
            gap_q     <= gap_d;
            gap_vld_q <= gap_vld_d;
            early_q   <= early_d;
            late_q    <= late_d;
            locked_q  <= locked_d;
        end
    end

    assign locked    = locked_q;
    assign err_early = early_q;
    assign err_late  = late_q;
    assign gap       = gap_q;
    assign gap_vld   = gap_vld_q;

`ifdef DELAY_MONITOR_STATS_EN
    logic [15:0] miss_q;

    // Updated on the same edge as the error pulse, so the count already
    // includes the error it is presented with.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_q <= '0;
        end else if ((early_d || late_d) && (miss_q != 16'hFFFF)) begin
            miss_q <= miss_q + 16'd1;
        end
    end

    assign miss_cnt = miss_q;
`else
    // Statistics disabled: no miss counter.
`endif

endmodule
